// File: rtl/tpu_pkg.sv
// Shared types and helpers for the TPU operand sequencer.
package tpu_pkg;

    localparam int TPU_DW = 8;
    localparam int TPU_K  = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        FLUSH,
        DONE
    } seq_state_e;

    typedef logic [TPU_DW-1:0]                operand_t;
    typedef operand_t [TPU_K-1:0]             row_t;
    typedef operand_t [TPU_K-1:0][TPU_K-1:0]  weight_t;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth (valid,data) shift register; DEPTH=0 is a plain wire.
module skew_delay_line #(
    parameter int DEPTH = 0,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            // The zero-depth lane has no state, so the clock and reset are intentionally left unused.
            logic w_unused;
            assign w_unused = clk ^ rst;
            assign o_valid  = i_valid;
            assign o_data   = i_data;
        end else begin : g_shift
            logic [DEPTH-1:0]         r_valid;
            logic [DEPTH-1:0][DW-1:0] r_data;

            // Shift the element one stage per cycle; reset discards anything in flight.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= '0;
                    r_data  <= '0;
                end else begin
                    r_valid[0] <= i_valid;
                    r_data[0]  <= i_data;
                    for (int s = 1; s < DEPTH; s++) begin
                        r_valid[s] <= r_valid[s-1];
                        r_data[s]  <= r_data[s-1];
                    end
                end
            end

            assign o_valid = r_valid[DEPTH-1];
            assign o_data  = r_data[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/tpu_operand_sequencer.sv
// Feeds a KxK systolic array: loads weights, streams skewed data rows, drains, then pulses done.
module tpu_operand_sequencer
    import tpu_pkg::*;
#(
    parameter int K         = 2,
    parameter int DW        = TPU_DW,
    parameter int MAX_ROWS  = 8,
    parameter int WLOAD_CYC = 1,
    parameter int DRAIN_CYC = 2,
    localparam int RW       = $clog2(MAX_ROWS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [K-1:0][K-1:0][DW-1:0]    cfg_weights,
    input  logic [RW-1:0]                  cfg_rows,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [K-1:0][DW-1:0]           in_data,
    output logic                           arr_load_weights,
    output logic [K-1:0][K-1:0][DW-1:0]    arr_weights,
    output logic                           arr_start,
    output logic [K-1:0][DW-1:0]           arr_data,
    output logic                           busy,
    output logic                           done
);

    localparam int              FLUSH_CYC  = K - 1 + DRAIN_CYC;
    localparam int              PW         = $clog2(max_i(WLOAD_CYC, FLUSH_CYC) + 1);
    localparam logic [PW-1:0]   LOAD_INIT  = PW'(WLOAD_CYC - 1);
    localparam logic [PW-1:0]   FLUSH_INIT = (FLUSH_CYC > 0) ? PW'(FLUSH_CYC - 1) : '0;
    localparam logic [RW-1:0]   ROWS_MAX   = RW'(MAX_ROWS);

    seq_state_e                    r_state;
    seq_state_e                    w_next_state;
    logic [RW-1:0]                 r_rows_left;
    logic [RW-1:0]                 w_rows_next;
    logic [RW-1:0]                 w_rows_clamped;
    logic [PW-1:0]                 r_phase;
    logic [PW-1:0]                 w_phase_next;
    logic                          r_cfg_ready;
    logic                          r_in_ready;
    logic                          r_load;
    logic                          r_busy;
    logic                          r_done;
    logic [K-1:0][K-1:0][DW-1:0]   r_weights;
    logic                          w_cfg_fire;
    logic                          w_accept;
    logic                          r_s0_valid;
    logic [K-1:0][DW-1:0]          r_s0_data;
    logic [K-1:0]                  w_lane_valid;
    logic [K-1:0][DW-1:0]          w_lane_data;

    assign w_cfg_fire     = r_cfg_ready & cfg_valid;
    assign w_accept       = r_in_ready & in_valid;
    assign w_rows_clamped = (cfg_rows > ROWS_MAX) ? ROWS_MAX : cfg_rows;

    // Next-state, row-count and phase-count decisions for the burst sequence.
    always_comb begin
        w_next_state = r_state;
        w_rows_next  = r_rows_left;
        w_phase_next = r_phase;
        case (r_state)
            IDLE: begin
                if (w_cfg_fire) begin
                    w_next_state = LOAD;
                    w_phase_next = LOAD_INIT;
                    w_rows_next  = w_rows_clamped;
                end
            end
            LOAD: begin
                if (r_phase == '0) begin
                    if (r_rows_left == '0) begin
                        w_next_state = (FLUSH_CYC > 0) ? FLUSH : DONE;
                        w_phase_next = FLUSH_INIT;
                    end else begin
                        w_next_state = STREAM;
                    end
                end else begin
                    w_phase_next = r_phase - PW'(1);
                end
            end
            STREAM: begin
                if (w_accept && (r_rows_left != '0)) begin
                    w_rows_next = r_rows_left - RW'(1);
                    if (r_rows_left == RW'(1)) begin
                        w_next_state = (FLUSH_CYC > 0) ? FLUSH : DONE;
                        w_phase_next = FLUSH_INIT;
                    end
                end
            end
            FLUSH: begin
                if (r_phase == '0) begin
                    w_next_state = DONE;
                end else begin
                    w_phase_next = r_phase - PW'(1);
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, counters, captured weights and all handshake/status outputs registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rows_left <= '0;
            r_phase     <= '0;
            r_weights   <= '0;
            r_cfg_ready <= 1'b1;
            r_in_ready  <= 1'b0;
            r_load      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_rows_left <= w_rows_next;
            r_phase     <= w_phase_next;
            if (w_cfg_fire) begin
                r_weights <= cfg_weights;
            end
            r_cfg_ready <= (w_next_state == IDLE);
            r_in_ready  <= (w_next_state == STREAM) && (w_rows_next != '0);
            r_load      <= (w_next_state == LOAD);
            r_busy      <= (w_next_state != IDLE);
            r_done      <= (w_next_state == DONE);
        end
    end

    // Skew stage 0: capture an accepted row, or a zero bubble when nothing is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_data  <= '0;
        end else begin
            r_s0_valid <= w_accept;
            r_s0_data  <= w_accept ? in_data : '0;
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_lane
        skew_delay_line #(
            .DEPTH (i),
            .DW    (DW)
        ) u_skew (
            .clk     (clk),
            .rst     (rst),
            .i_valid (r_s0_valid),
            .i_data  (r_s0_data[i]),
            .o_valid (w_lane_valid[i]),
            .o_data  (w_lane_data[i])
        );
        assign arr_data[i] = w_lane_valid[i] ? w_lane_data[i] : '0;
    end

    assign arr_start        = |w_lane_valid;
    assign arr_load_weights = r_load;
    assign arr_weights      = r_load ? r_weights : '0;
    assign cfg_ready        = r_cfg_ready;
    assign in_ready         = r_in_ready;
    assign busy             = r_busy;
    assign done             = r_done;

endmodule

// File: tb/tb_tpu_operand_sequencer.sv
// Self-checking bench for tpu_operand_sequencer: timeline model plus directed and random bursts.
module tb_tpu_operand_sequencer;

    localparam int K         = 2;
    localparam int DW        = 8;
    localparam int MAX_ROWS  = 8;
    localparam int WLOAD_CYC = 1;
    localparam int DRAIN_CYC = 2;
    localparam int RW        = $clog2(MAX_ROWS + 1);
    localparam int FLUSH_CYC = K - 1 + DRAIN_CYC;
    localparam int HIST      = 64;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         cfg_valid;
    logic                         cfg_ready;
    logic [K-1:0][K-1:0][DW-1:0]  cfg_weights;
    logic [RW-1:0]                cfg_rows;
    logic                         in_valid;
    logic                         in_ready;
    logic [K-1:0][DW-1:0]         in_data;
    logic                         arr_load_weights;
    logic [K-1:0][K-1:0][DW-1:0]  arr_weights;
    logic                         arr_start;
    logic [K-1:0][DW-1:0]         arr_data;
    logic                         busy;
    logic                         done;

    always #5 clk = ~clk;

    tpu_operand_sequencer #(
        .K         (K),
        .DW        (DW),
        .MAX_ROWS  (MAX_ROWS),
        .WLOAD_CYC (WLOAD_CYC),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_weights      (cfg_weights),
        .cfg_rows         (cfg_rows),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .arr_load_weights (arr_load_weights),
        .arr_weights      (arr_weights),
        .arr_start        (arr_start),
        .arr_data         (arr_data),
        .busy             (busy),
        .done             (done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Timeline model: a burst is described by its config cycle, row count, rows taken and done cycle.
    bit                           m_active = 1'b0;
    int                           m_c0;
    int                           m_n;
    int                           m_acc;
    int                           m_done_at;
    logic [K-1:0][K-1:0][DW-1:0]  m_weights;
    bit                           h_valid [HIST];
    logic [K-1:0][DW-1:0]         h_row   [HIST];

    // Outputs sampled at the falling edge of the most recent cycle.
    logic                         s_cfg_ready, s_in_ready, s_load, s_start, s_busy, s_done;
    logic [K-1:0][DW-1:0]         s_data;
    logic [K-1:0][K-1:0][DW-1:0]  s_weights;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, compare against the model, advance the model.
    task automatic stepCycle();
        logic                         e_busy, e_load, e_ready, e_done, e_start;
        logic [K-1:0][DW-1:0]         e_data;
        logic [K-1:0][K-1:0][DW-1:0]  e_weights;
        int                           j;
        @(negedge clk);
        s_cfg_ready = cfg_ready;
        s_in_ready  = in_ready;
        s_load      = arr_load_weights;
        s_start     = arr_start;
        s_busy      = busy;
        s_done      = done;
        s_data      = arr_data;
        s_weights   = arr_weights;
        if (rst) begin
            checkOutput("rst_busy",      64'(s_busy),      64'(0));
            checkOutput("rst_cfg_ready", 64'(s_cfg_ready), 64'(1));
            checkOutput("rst_in_ready",  64'(s_in_ready),  64'(0));
            checkOutput("rst_load",      64'(s_load),      64'(0));
            checkOutput("rst_weights",   64'(s_weights),   64'(0));
            checkOutput("rst_start",     64'(s_start),     64'(0));
            checkOutput("rst_data",      64'(s_data),      64'(0));
            checkOutput("rst_done",      64'(s_done),      64'(0));
            m_active = 1'b0;
            for (int h = 0; h < HIST; h++) begin
                h_valid[h] = 1'b0;
                h_row[h]   = '0;
            end
        end else begin
            e_busy    = m_active && (cyc > m_c0);
            e_load    = e_busy && (cyc <= m_c0 + WLOAD_CYC);
            e_ready   = e_busy && (m_n > 0) && (cyc > m_c0 + WLOAD_CYC) && (m_acc < m_n);
            e_done    = e_busy && (cyc == m_done_at);
            e_weights = e_load ? m_weights : '0;
            e_start   = 1'b0;
            for (int i = 0; i < K; i++) begin
                j = (((cyc - 1 - i) % HIST) + HIST) % HIST;
                e_data[i] = h_valid[j] ? h_row[j][i] : '0;
                e_start   = e_start | h_valid[j];
            end
            checkOutput("busy",      64'(s_busy),      64'(e_busy));
            checkOutput("cfg_ready", 64'(s_cfg_ready), 64'(!e_busy));
            checkOutput("in_ready",  64'(s_in_ready),  64'(e_ready));
            checkOutput("load",      64'(s_load),      64'(e_load));
            checkOutput("weights",   64'(s_weights),   64'(e_weights));
            checkOutput("start",     64'(s_start),     64'(e_start));
            checkOutput("data",      64'(s_data),      64'(e_data));
            checkOutput("done",      64'(s_done),      64'(e_done));
            j = cyc % HIST;
            h_valid[j] = 1'b0;
            h_row[j]   = '0;
            if (e_ready && in_valid) begin
                h_valid[j] = 1'b1;
                h_row[j]   = in_data;
                m_acc++;
                if (m_acc == m_n) m_done_at = cyc + 1 + FLUSH_CYC;
            end
            if (e_done) begin
                m_active = 1'b0;
            end else if (!m_active && cfg_valid) begin
                m_active  = 1'b1;
                m_c0      = cyc;
                m_n       = (int'(cfg_rows) > MAX_ROWS) ? MAX_ROWS : int'(cfg_rows);
                m_acc     = 0;
                m_weights = cfg_weights;
                m_done_at = (m_n == 0) ? cyc + WLOAD_CYC + 1 + FLUSH_CYC : -1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Offer a burst descriptor for one cycle (the sequencer is expected to be idle).
    task automatic applyStimulus(input int rows, input logic [K-1:0][K-1:0][DW-1:0] w);
        cfg_valid   = 1'b1;
        cfg_rows    = RW'(rows);
        cfg_weights = w;
        stepCycle();
        cfg_valid   = 1'b0;
    endtask

    // Run cycles until the model finishes its burst, with optional random stimulus and reset.
    task automatic runBurst(input bit rand_in, input int reset_at);
        int n = 0;
        while (m_active && n < 200) begin
            if (rand_in) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = K*DW'($urandom);
                cfg_valid = $urandom_range(0, 1) != 0;
                cfg_rows  = RW'($urandom_range(0, 12));
            end
            if (n == reset_at) rst = 1'b1;
            stepCycle();
            n++;
        end
        checkOutput("burst_timeout", 64'(m_active), 64'(0));
        rst       = 1'b0;
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        stepCycle();
    endtask

    initial begin
        int a, cnt_start, cnt_load, cnt_done, cnt_acc, d_cyc;
        rst         = 1'b1;
        cfg_valid   = 1'b0;
        cfg_rows    = '0;
        cfg_weights = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        stepCycle();

        // Reset in the middle of a streaming burst.
        applyStimulus(3, 32'hA1B2C3D4);
        in_valid = 1'b1;
        in_data  = {8'h22, 8'h11};
        stepCycle();
        stepCycle();
        stepCycle();
        rst = 1'b1;
        stepCycle();
        checkOutput("t1_busy",      64'(s_busy),      64'(0));
        checkOutput("t1_cfg_ready", 64'(s_cfg_ready), 64'(1));
        rst      = 1'b0;
        in_valid = 1'b0;
        stepCycle();

        // Two back-to-back rows with literal expectations.
        applyStimulus(2, 32'h04030201);
        in_valid = 1'b1;
        in_data  = {8'd6, 8'd5};
        stepCycle();
        checkOutput("t2_load",    64'(s_load),    64'(1));
        checkOutput("t2_weights", 64'(s_weights), 64'h04030201);
        stepCycle();
        checkOutput("t2_ready", 64'(s_in_ready), 64'(1));
        in_data = {8'd8, 8'd7};
        stepCycle();
        checkOutput("t2_lane0_a", 64'(s_data[0]), 64'd5);
        checkOutput("t2_start",   64'(s_start),   64'(1));
        in_valid = 1'b0;
        stepCycle();
        checkOutput("t2_lane0_b", 64'(s_data[0]), 64'd7);
        checkOutput("t2_lane1_a", 64'(s_data[1]), 64'd6);
        stepCycle();
        checkOutput("t2_lane1_b", 64'(s_data[1]), 64'd8);
        checkOutput("t2_lane0_z", 64'(s_data[0]), 64'd0);
        stepCycle();
        checkOutput("t2_not_done", 64'(s_done), 64'(0));
        stepCycle();
        checkOutput("t2_done", 64'(s_done), 64'(1));
        stepCycle();

        // Rows with a bubble between them.
        applyStimulus(2, 32'h10203040);
        stepCycle();
        in_valid = 1'b1;
        in_data  = {8'h12, 8'h11};
        stepCycle();
        in_valid = 1'b0;
        stepCycle();
        checkOutput("t3_lane0_a", 64'(s_data[0]), 64'h11);
        in_valid = 1'b1;
        in_data  = {8'h22, 8'h21};
        stepCycle();
        checkOutput("t3_lane0_bub", 64'(s_data[0]), 64'h0);
        checkOutput("t3_lane1_a",   64'(s_data[1]), 64'h12);
        in_valid = 1'b0;
        stepCycle();
        checkOutput("t3_lane0_b",   64'(s_data[0]), 64'h21);
        checkOutput("t3_lane1_bub", 64'(s_data[1]), 64'h0);
        stepCycle();
        checkOutput("t3_lane1_b", 64'(s_data[1]), 64'h22);
        runBurst(1'b0, -1);

        // Empty burst: weights load, no data, done still pulses.
        applyStimulus(0, 32'h55667788);
        cnt_start = 0;
        cnt_load  = 0;
        cnt_done  = 0;
        a = 0;
        while (m_active && a < 50) begin
            in_valid = 1'b1;
            stepCycle();
            cnt_start += int'(s_start);
            cnt_load  += int'(s_load);
            cnt_done  += int'(s_done);
            a++;
        end
        in_valid = 1'b0;
        checkOutput("t4_start_cnt", 64'(cnt_start), 64'(0));
        checkOutput("t4_load_cnt",  64'(cnt_load),  64'(WLOAD_CYC));
        checkOutput("t4_done_cnt",  64'(cnt_done),  64'(1));
        stepCycle();

        // cfg_valid held through a burst; next descriptor taken the cycle after done.
        cfg_valid   = 1'b1;
        cfg_rows    = RW'(1);
        cfg_weights = 32'hDEADBEEF;
        stepCycle();
        cfg_rows = RW'(2);
        in_valid = 1'b1;
        in_data  = {8'h44, 8'h33};
        d_cyc    = -1;
        a = 0;
        while (m_active && a < 50) begin
            stepCycle();
            if (s_done) d_cyc = cyc - 1;
            a++;
        end
        stepCycle();
        checkOutput("t5_ready_after_done", 64'(s_cfg_ready), 64'(1));
        checkOutput("t5_done_seen",        64'(cyc - 1 - d_cyc), 64'(1));
        cfg_valid = 1'b0;
        runBurst(1'b0, -1);

        // Oversized row count is clamped.
        applyStimulus(MAX_ROWS + 3, 32'h01010101);
        in_valid = 1'b1;
        cnt_acc  = 0;
        a = 0;
        while (m_active && a < 60) begin
            in_data = K*DW'($urandom);
            stepCycle();
            if (s_in_ready && in_valid) cnt_acc++;
            a++;
        end
        in_valid = 1'b0;
        checkOutput("t6_rows_taken", 64'(cnt_acc), 64'(MAX_ROWS));
        stepCycle();

        // Random bursts, some interrupted by reset.
        for (int b = 0; b < 40; b++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) stepCycle();
            applyStimulus($urandom_range(0, 12), K*K*DW'($urandom));
            runBurst(1'b1, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
